// File: rtl/mips_defs.sv
// mips_defs: shared ALU op codes, opcode/funct fields, FSM states and instruction classes
package mips_defs;
    localparam logic [4:0] RA_IDX = 5'd31;
    localparam logic [3:0] ALU_ADDU = 4'b0000;
    localparam logic [3:0] ALU_SUBU = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SGTU = 4'b1000;
    localparam logic [3:0] ALU_SGT  = 4'b1001;
    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_LUI = 6'b001111;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_JR   = 6'b001000;
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;
    localparam logic [3:0] C_ILL   = 4'd0;
    localparam logic [3:0] C_RALU  = 4'd1;
    localparam logic [3:0] C_SHIFT = 4'd2;
    localparam logic [3:0] C_ORI   = 4'd3;
    localparam logic [3:0] C_LUI   = 4'd4;
    localparam logic [3:0] C_LW    = 4'd5;
    localparam logic [3:0] C_SW    = 4'd6;
    localparam logic [3:0] C_BEQ   = 4'd7;
    localparam logic [3:0] C_J     = 4'd8;
    localparam logic [3:0] C_JAL   = 4'd9;
    localparam logic [3:0] C_JR    = 4'd10;
endpackage

// File: rtl/instr_class_dec.sv
// instr_class_dec: combinational opcode/funct -> instruction class and ALU op decoder
//   op     in  opcode field instr[31:26]
//   funct  in  funct field instr[5:0]
//   cls    out instruction class (C_* codes)
//   alu_op out ALU operation for the class (ADDU for classes that do not use the ALU)
module instr_class_dec
    import mips_defs::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [3:0] cls,
    output logic [3:0] alu_op
);
    always_comb begin
        cls = C_ILL;
        alu_op = ALU_ADDU;
        case (op)
            OP_R: begin
                case (funct)
                    FN_ADDU: begin cls = C_RALU;  alu_op = ALU_ADDU; end
                    FN_SUBU: begin cls = C_RALU;  alu_op = ALU_SUBU; end
                    FN_AND:  begin cls = C_RALU;  alu_op = ALU_AND;  end
                    FN_OR:   begin cls = C_RALU;  alu_op = ALU_OR;   end
                    FN_XOR:  begin cls = C_RALU;  alu_op = ALU_XOR;  end
                    FN_SLL:  begin cls = C_SHIFT; alu_op = ALU_SLL;  end
                    FN_SRL:  begin cls = C_SHIFT; alu_op = ALU_SRL;  end
                    FN_SRA:  begin cls = C_SHIFT; alu_op = ALU_SRA;  end
                    FN_JR:   cls = C_JR;
                    default: cls = C_ILL;
                endcase
            end
            OP_ORI: begin cls = C_ORI; alu_op = ALU_OR; end
            OP_LUI: cls = C_LUI;
            OP_LW:  cls = C_LW;
            OP_SW:  cls = C_SW;
            OP_BEQ: begin cls = C_BEQ; alu_op = ALU_SUBU; end
            OP_J:   cls = C_J;
            OP_JAL: cls = C_JAL;
            default: cls = C_ILL;
        endcase
    end
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the MIPS datapath
//   clk, reset (async, active-high)   instr: IR contents   zero: ALU result == 0
//   pc_we/pc_src, ir_we, reg_we/reg_dst/wd_sel, alu_src_a/alu_src_b/ext_op/alu_op,
//   mem_we: datapath controls   illegal: DECODE pulse on bad encoding   state: debug
module mc_ctrl
    import mips_defs::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        ir_we,
    output logic        reg_we,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wd_sel,
    output logic        alu_src_a,
    output logic        alu_src_b,
    output logic [1:0]  ext_op,
    output logic [3:0]  alu_op,
    output logic        mem_we,
    output logic        illegal,
    output logic [2:0]  state
);
    state_t st, nxt;
    logic [3:0] cls, dec_op;
    logic is_jump, is_rr, is_mem, unused_bits;
    instr_class_dec u_dec (
        .op(instr[31:26]),
        .funct(instr[5:0]),
        .cls(cls),
        .alu_op(dec_op)
    );
    assign unused_bits = ^instr[25:6];
    assign is_jump = cls == C_J || cls == C_JAL || cls == C_JR;
    assign is_rr = cls == C_RALU || cls == C_SHIFT;
    assign is_mem = cls == C_LW || cls == C_SW;
    assign state = st;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) st <= S_FETCH;
        else st <= nxt;
    end
    always_comb begin
        nxt = S_FETCH;
        pc_we = 1'b0;
        pc_src = 2'd0;
        ir_we = 1'b0;
        reg_we = 1'b0;
        reg_dst = 2'd0;
        wd_sel = 2'd0;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        ext_op = 2'd0;
        alu_op = ALU_ADDU;
        mem_we = 1'b0;
        illegal = 1'b0;
        case (st)
            S_FETCH: begin
                ir_we = 1'b1;
                pc_we = 1'b1;
                nxt = S_DECODE;
            end
            S_DECODE: begin
                nxt = (is_jump || cls == C_ILL) ? S_FETCH : S_EXEC;
                pc_we = is_jump;
                pc_src = cls == C_JR ? 2'd3 : is_jump ? 2'd2 : 2'd0;
                reg_we = cls == C_JAL;
                reg_dst = cls == C_JAL ? 2'd2 : 2'd0;
                wd_sel = cls == C_JAL ? 2'd2 : 2'd0;
                illegal = cls == C_ILL;
            end
            S_EXEC: begin
                pc_we = cls == C_BEQ && zero;
                pc_src = pc_we ? 2'd1 : 2'd0;
                nxt = is_mem ? S_MEM : (is_rr || cls == C_ORI || cls == C_LUI) ? S_WB : S_FETCH;
            end
            S_MEM: begin
                mem_we = cls == C_SW;
                nxt = cls == C_LW ? S_WB : S_FETCH;
            end
            S_WB: begin
                reg_we = 1'b1;
                reg_dst = is_rr ? 2'd1 : 2'd0;
                wd_sel = cls == C_LW ? 2'd1 : 2'd0;
            end
            default: nxt = S_FETCH;
        endcase
        // ALU controls stay valid through MEM/WB so the unregistered ALU result survives
        if (st == S_EXEC || st == S_MEM || st == S_WB) begin
            alu_op = dec_op;
            alu_src_a = cls == C_SHIFT || cls == C_LUI;
            alu_src_b = cls == C_ORI || cls == C_LUI || is_mem;
            ext_op = cls == C_LUI ? 2'd2 : is_mem ? 2'd1 : 2'd0;
        end
        if (reset) begin
            pc_we = 1'b0;
            pc_src = 2'd0;
            ir_we = 1'b0;
            reg_we = 1'b0;
            reg_dst = 2'd0;
            wd_sel = 2'd0;
            alu_src_a = 1'b0;
            alu_src_b = 1'b0;
            ext_op = 2'd0;
            alu_op = ALU_ADDU;
            mem_we = 1'b0;
            illegal = 1'b0;
        end
    end
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control FSM for the single-issue MIPS core; the producer side of the ALU's 4-bit operation interface.
- Classifies the instruction held in IR, steps through FETCH/DECODE/EXEC/MEM/WB, and drives ALUOp plus all datapath selects and write enables.
- Sits between the IR and the PC/GRF/ALU/DM datapath.

Parameters:
- RA_IDX, 5'd31, GRF index written by jal.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; returns FSM to FETCH.
- instr  in  32  current IR contents.
- zero  in  1  ALU result == 0, sampled in EXEC for beq.
- pc_we  out  1  PC write enable.
- pc_src  out  2  0=PC+4, 1=branch target, 2=jump {PC[31:28],idx,00}, 3=GRF[rs].
- ir_we  out  1  IR write enable.
- reg_we  out  1  GRF write enable.
- reg_dst  out  2  0=rt, 1=rd, 2=RA_IDX.
- wd_sel  out  2  0=ALU result, 1=DM read data, 2=PC+4.
- alu_src_a  out  1  0=GRF[rs], 1=zero-extended shamt.
- alu_src_b  out  1  0=GRF[rt], 1=extended imm.
- ext_op  out  2  0=zero-extend, 1=sign-extend, 2=imm<<16.
- alu_op  out  4  ALU operation code.
- mem_we  out  1  DM write enable.
- illegal  out  1  one-cycle pulse in DECODE for an unsupported encoding.
- state  out  3  current state, for debug.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset:
  - State goes to FETCH immediately.
  - While reset is high, pc_we, ir_we, reg_we, mem_we and illegal are forced 0.
  - All selects and alu_op are 0 while reset is high.
  - The first FETCH occurs on the first rising edge after deassertion.
  - Reset mid-instruction abandons that instruction; no write enable asserts afterwards.
- Outputs are combinational from state and instr (Moore per class). Outside the listed cycles, enables are 0 and selects are 0.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Codes 5-7 go to FETCH on the next edge with all enables 0.
- FETCH: ir_we=1, pc_we=1, pc_src=0. Next state is DECODE.
- DECODE: classify instr. Next state per class:
  - R-ALU (funct addu/subu/and/or/xor/sll/srl/sra), ori, lui, lw, sw, beq -> EXEC.
  - j: pc_we=1, pc_src=2 -> FETCH.
  - jal: pc_we=1, pc_src=2, reg_we=1, reg_dst=2, wd_sel=2 -> FETCH. PC+4 is the value captured before the PC update.
  - jr: pc_we=1, pc_src=3 -> FETCH.
  - Illegal: illegal=1 for this cycle only -> FETCH. No other effect.
- EXEC, alu_op by class:
  - addu 0000, subu 0001, and 0010, or 0011, xor 0100, sll 0101, srl 0110, sra 0111.
  - Shifts: alu_src_a=1. Operand B is rt.
  - ori: alu_op 0011, alu_src_b=1, ext_op=0.
  - lui: alu_op 0000, operand A forced to shamt path (alu_src_a=1; shamt field is 0 for lui), alu_src_b=1, ext_op=2.
  - lw/sw: alu_op 0000, alu_src_b=1, ext_op=1.
  - beq: alu_op 0001, alu_src_b=0. If zero=1: pc_we=1, pc_src=1. Next state is FETCH.
  - Next state: R-ALU/ori/lui -> WB; lw/sw -> MEM.
  - EXEC control is held stable through MEM/WB so the ALU result persists without an extra register.
- MEM:
  - sw: mem_we=1 -> FETCH.
  - lw: -> WB.
- WB:
  - reg_we=1. reg_dst=1 for R-ALU, 0 otherwise. wd_sel=1 for lw, 0 otherwise.
  - Next state is FETCH.
- Latency in cycles: j/jal/jr/illegal 2; beq 3; R-ALU/ori/lui/sw 4; lw 5.
- Reserved alu_op codes 1000 (SGTU) and 1001 (SGT) are defined but not issued by this ISA subset.
- nop (all zeros) decodes as sll $0 and is legal. Its write to $0 is suppressed in the GRF, not here.
- At most one of pc_we/reg_we/mem_we paths targets a given resource per cycle. jal asserts pc_we and reg_we together.

Decomposition:
- Shared package mips_defs holds:
  - ALUOp constants (0000-1001 as above).
  - Opcode constants: R=000000, ori=001101, lui=001111, lw=100011, sw=101011, beq=000100, j=000010, jal=000011.
  - funct codes, including jr=001000.
  - State encodings.
  - Instruction-class encoding.
- One sub-module: instr_class_dec, a combinational instr -> class (plus alu_op) decoder. It is reused later by the pipelined core.

Test Plan:
- reset high for 3 cycles mid-EXEC of lw, then release -> all enables 0 during reset; state=0; ir_we=1 on the first cycle after release.
- addu $3,$1,$2 (0x00221821) -> states 0,1,2,4; alu_op=0000 in EXEC; reg_we=1, reg_dst=1, wd_sel=0 in WB only.
- lw $5,8($4) (0x8C850008) -> 5 cycles; alu_op=0000, ext_op=1, alu_src_b=1; WB has wd_sel=1, reg_dst=0; mem_we never 1.
- beq with zero=1, then zero=0 -> pc_we=1, pc_src=1 in EXEC for the first case; pc_we=0 in EXEC for the second; both return to FETCH after 3 cycles.
- jal 0x0C000010 -> DECODE has pc_we=1, pc_src=2, reg_we=1, reg_dst=2, wd_sel=2; next state FETCH.
- opcode 111111 -> illegal=1 for one cycle in DECODE; no writes; FETCH follows.
